freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Downstream stage of the clock-divider block.
- Consumes the divided square wave, which toggles once per input-signal period. Counts its transitions over a fixed gate window timed from the fast internal clock.
- Publishes the result as packed BCD for the seven-segment display driver.
- Because every transition equals one input period, the latched count is the input frequency in Hz when the gate is 1 s.

Parameters:
- GATE_CYCLES, 50_000_000: clk_inner cycles per gate window (1 s at 50 MHz); must be ≥ 2.
- DIGITS, 5: number of BCD decades in the count and the output.

Ports:
- clk_inner, input, 1: sole clock; all logic is on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- sig_div, input, 1: divided signal from the divider stage, already synchronous to clk_inner.
- hold, input, 1: when 1, freezes the displayed result; measurement continues.
- freq_bcd, output, 4*DIGITS: latched count; digit k occupies bits [4k+3:4k], with k=0 the units digit.
- valid, output, 1: one-cycle pulse when freq_bcd is updated.
- ovf, output, 1: latched with freq_bcd; 1 means the window count exceeded the BCD range.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - gate counter=0, BCD accumulator=0, sticky overflow=0, sig_prev=0.
  - freq_bcd=0, valid=0, ovf=0.
  - Reset asserted mid-window discards the partial count; no valid pulse is produced.
- Edge detect:
  - edge = sig_div XOR sig_prev; sig_prev <= sig_div every cycle.
  - Both rising and falling transitions count.
  - If sig_div=1 on the first cycle after reset, that cycle counts as one edge.
- Gate counter:
  - Runs 0 .. GATE_CYCLES-1 and wraps.
  - The cycle where it equals GATE_CYCLES-1 is the terminal cycle (TC).
- Accumulator:
  - DIGITS cascaded decades; an edge increments the units decade.
  - A decade rolls 9→0 and carries into the next decade in the same cycle.
- Saturation:
  - If all decades are 9 and an edge arrives, the accumulator holds all-9s and sticky overflow is set.
  - Further edges in the same window change nothing.
- At TC:
  - The latched value = accumulator plus this cycle's edge, with the same saturation rule.
  - If hold=0: freq_bcd <= latched value; ovf <= overflow (including any overflow caused in TC).
  - If hold=0, valid=1 in the following cycle only. If hold=1, freq_bcd, ovf and valid are unchanged.
  - Accumulator and sticky overflow clear to 0. An edge in the cycle after TC is counted as the first edge of the new window.
- No edge is lost or double-counted across a window boundary.
- Latency: freq_bcd/ovf change at the clock edge ending TC; valid is high during the cycle immediately after TC.
- Maximum countable rate: one edge per cycle, so the full scale is min(GATE_CYCLES, 10^DIGITS - 1).
- Width rules:
  - The gate counter is sized by clog2(GATE_CYCLES).
  - BCD digits never hold values above 9.

Decomposition:
- Shared package: digit width constant (4), BCD max digit constant (9), default GATE_CYCLES for the 50 MHz board clock.
- Natural sub-module: bcd_decade.
  - Inputs: clock, synchronous reset, clear, inc, sat.
  - Outputs: 4-bit digit, carry.
  - Instantiate DIGITS copies in a generate chain. The top level owns the gate counter, edge detect, saturation and output latch.

Test Plan:
- GATE_CYCLES=100, DIGITS=3; sig_div held low -> after each TC freq_bcd=0x000, ovf=0; valid pulses every 100 cycles, one cycle wide.
- sig_div toggles every 4 cycles, starting low -> 25 edges per window; from the second window on, freq_bcd=0x025, ovf=0.
- An edge placed exactly on TC and another on the cycle after TC, with no other edges -> window N reports 0x001 and window N+1 reports 0x001; total reported equals total edges.
- DIGITS=2, GATE_CYCLES=150, sig_div toggling every cycle -> freq_bcd=0x99, ovf=1; with toggling then stopped, the next window reports 0x00, ovf=0.
- hold=1 across a TC while input is at 25 edges/window -> freq_bcd keeps its previous value and no valid pulse. hold=0 at the next TC -> freq_bcd=0x025 and valid pulses.
- rst_n=0 for one cycle mid-window -> all outputs 0 the next cycle. The first valid appears 100 cycles after reset release and counts only post-reset edges.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the frequency meter: BCD digit geometry
// and the gate length that gives a 1 s window on the 50 MHz board clock.
package freq_meter_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam int GATE_CYCLES_50MHZ = 50_000_000;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/freq_meter_if.sv
// Signal bundle between the divider/display side and the frequency meter.
// The master modport is the meter itself; the slave side feeds it and reads results.
interface freq_meter_if #(
  parameter int DIGITS = 5
);
  import freq_meter_pkg::*;

  logic                      sig_div;
  logic                      hold;
  logic [DIGIT_W*DIGITS-1:0] freq_bcd;
  logic                      valid;
  logic                      ovf;

  modport master (
    input  sig_div,
    input  hold,
    output freq_bcd,
    output valid,
    output ovf
  );

  modport slave (
    output sig_div,
    output hold,
    input  freq_bcd,
    input  valid,
    input  ovf
  );

endinterface

// File: rtl/freq_meter_bcd_decade.sv
// One BCD decade of the edge accumulator: counts 0..9, rolls over and
// raises carry in the same cycle so decades chain combinationally.
module freq_meter_bcd_decade
  import freq_meter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       sat,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q, digit_d;

  // Clear wins over increment so the window boundary restarts from zero.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc && !sat) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Carry ignores sat: the top decade's carry is the overflow event itself.
  assign carry = inc && (digit_q == BCD_MAX);
  assign digit = digit_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts transitions of sig_div over GATE_CYCLES clocks
// and publishes the window total as packed BCD with a saturating overflow flag.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_50MHZ,
  parameter int DIGITS      = 5
) (
  input logic         clk_inner,
  input logic         rst_n,
  freq_meter_if.master bus
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam int BCD_W = DIGIT_W * DIGITS;

  typedef logic [BCD_W-1:0] bcd_vec_t;

  logic [GATE_W-1:0] gate_q, gate_d;
  logic              sig_prev_q, sig_prev_d;
  logic              ovf_sticky_q, ovf_sticky_d;
  bcd_vec_t          freq_bcd_q, freq_bcd_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;

  logic     edge_det;
  logic     tc;
  logic     ovf_evt;
  bcd_vec_t acc;
  bcd_vec_t latch_val;

  // Value the accumulator would take after this cycle's edge, pinned at all-9s on overflow.
  function automatic bcd_vec_t bcd_sat_inc(input bcd_vec_t val, input logic inc_in,
                                           input logic sat);
    bcd_vec_t   r;
    bcd_digit_t d;
    logic       c;
    r = val;
    c = inc_in;
    if (!sat) begin
      for (int k = 0; k < DIGITS; k++) begin
        d = val[DIGIT_W*k +: DIGIT_W];
        if (c) begin
          if (d == BCD_MAX) begin
            d = '0;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end
        r[DIGIT_W*k +: DIGIT_W] = d;
      end
    end
    return r;
  endfunction

  assign edge_det = bus.sig_div ^ sig_prev_q;
  assign tc       = (gate_q == GATE_LAST);

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    logic inc_k;
    logic carry_k;
    if (k == 0) begin : g_lsd
      assign inc_k = edge_det;
    end else begin : g_msd
      assign inc_k = g_dec[k-1].carry_k;
    end
    freq_meter_bcd_decade u_dec (
      .clk   (clk_inner),
      .rst_n (rst_n),
      .clr   (tc),
      .inc   (inc_k),
      .sat   (ovf_evt),
      .digit (acc[DIGIT_W*k +: DIGIT_W]),
      .carry (carry_k)
    );
  end

  // A carry out of the top decade means an edge arrived while every decade read 9.
  assign ovf_evt = g_dec[DIGITS-1].carry_k;

  always_comb begin
    gate_d       = tc ? '0 : gate_q + GATE_W'(1);
    sig_prev_d   = bus.sig_div;
    ovf_sticky_d = tc ? 1'b0 : (ovf_sticky_q | ovf_evt);
    latch_val    = bcd_sat_inc(acc, edge_det, ovf_evt);
    freq_bcd_d   = freq_bcd_q;
    ovf_d        = ovf_q;
    valid_d      = 1'b0;
    if (tc && !bus.hold) begin
      freq_bcd_d = latch_val;
      ovf_d      = ovf_sticky_q | ovf_evt;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_inner) begin
    if (!rst_n) begin
      gate_q       <= '0;
      sig_prev_q   <= 1'b0;
      ovf_sticky_q <= 1'b0;
      freq_bcd_q   <= '0;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      gate_q       <= gate_d;
      sig_prev_q   <= sig_prev_d;
      ovf_sticky_q <= ovf_sticky_d;
      freq_bcd_q   <= freq_bcd_d;
      ovf_q        <= ovf_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.freq_bcd = freq_bcd_q;
  assign bus.valid    = valid_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (100-cycle/3-digit and 150-cycle/2-digit)
// checked every cycle against an arithmetic window-count model plus literal checkpoints.
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a;
  logic rst_n_b;

  freq_meter_if #(.DIGITS(3)) if_a ();
  freq_meter_if #(.DIGITS(2)) if_b ();

  freq_meter #(.GATE_CYCLES(100), .DIGITS(3)) u_a (
    .clk_inner (clk),
    .rst_n     (rst_n_a),
    .bus       (if_a.master)
  );

  freq_meter #(.GATE_CYCLES(150), .DIGITS(2)) u_b (
    .clk_inner (clk),
    .rst_n     (rst_n_b),
    .bus       (if_b.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit b_done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count edges per window as an integer, report min(count, 10^D-1) in BCD.
  int         g_len[2] = '{100, 150};
  int         max_v[2] = '{999, 99};
  int         m_cnt[2];
  int         m_cyc[2];
  logic       m_prev[2];
  logic [11:0] e_bcd[2];
  logic       e_ovf[2];
  logic       e_vld[2];
  bit         live[2] = '{1'b0, 1'b0};

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input int k, input logic rn, input logic s, input logic h);
    if (!rn) begin
      m_cnt[k]  = 0;
      m_cyc[k]  = 0;
      m_prev[k] = 1'b0;
      e_bcd[k]  = '0;
      e_ovf[k]  = 1'b0;
      e_vld[k]  = 1'b0;
      live[k]   = 1'b1;
    end else if (live[k]) begin
      e_vld[k] = 1'b0;
      if (s != m_prev[k]) m_cnt[k]++;
      m_prev[k] = s;
      if ((m_cyc[k] % g_len[k]) == g_len[k] - 1) begin
        if (!h) begin
          e_bcd[k] = to_bcd((m_cnt[k] > max_v[k]) ? max_v[k] : m_cnt[k]);
          e_ovf[k] = (m_cnt[k] > max_v[k]);
          e_vld[k] = 1'b1;
        end
        m_cnt[k] = 0;
      end
      m_cyc[k]++;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_n_a, if_a.sig_div, if_a.hold);
    model_step(1, rst_n_b, if_b.sig_div, if_b.hold);
  end

  always @(negedge clk) begin
    if (live[0]) begin
      chk("a_freq_bcd", 32'(if_a.freq_bcd), 32'(e_bcd[0]));
      chk("a_valid",    32'(if_a.valid),    32'(e_vld[0]));
      chk("a_ovf",      32'(if_a.ovf),      32'(e_ovf[0]));
    end
    if (live[1]) begin
      chk("b_freq_bcd", 32'(if_b.freq_bcd), 32'(e_bcd[1][7:0]));
      chk("b_valid",    32'(if_b.valid),    32'(e_vld[1]));
      chk("b_ovf",      32'(if_b.ovf),      32'(e_ovf[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Toggle sig_div on every per-th cycle (per=0: hold steady) and count valid pulses seen.
  task automatic run_toggle_a(input int n, input int per, output int nv);
    nv = 0;
    for (int i = 0; i < n; i++) begin
      if (per > 0 && (i % per) == per - 1) if_a.sig_div = ~if_a.sig_div;
      tick();
      if (if_a.valid) nv++;
    end
  endtask

  task automatic wait_phase_a(input int p);
    int guard;
    guard = 0;
    while ((m_cyc[0] % 100) != p && guard < 200) begin
      tick();
      guard++;
    end
  endtask

  task automatic wait_valid_a(input int budget);
    int c;
    c = 0;
    while (!if_a.valid && c < budget) begin
      tick();
      c++;
    end
    chk("a_valid_seen", 32'(if_a.valid), 32'd1);
  endtask

  initial begin : stim_a
    int nv;
    int cnt;
    int guard;
    if_a.sig_div = 1'b0;
    if_a.hold    = 1'b0;
    rst_n_a      = 1'b0;
    tick();
    tick();
    chk("a_rst_bcd",   32'(if_a.freq_bcd), 32'h0);
    chk("a_rst_valid", 32'(if_a.valid),    32'h0);
    chk("a_rst_ovf",   32'(if_a.ovf),      32'h0);
    rst_n_a = 1'b1;

    // Quiet input: two windows, one-cycle valid each, zero count.
    run_toggle_a(200, 0, nv);
    chk("a_quiet_valid_count", 32'(nv), 32'd2);
    chk("a_quiet_bcd", 32'(if_a.freq_bcd), 32'h000);

    // Toggle every 4 cycles: 25 edges per window.
    run_toggle_a(300, 4, nv);
    chk("a_toggle_valid_count", 32'(nv), 32'd3);
    chk("a_toggle25_bcd", 32'(if_a.freq_bcd), 32'h025);
    chk("a_toggle25_ovf", 32'(if_a.ovf), 32'h0);

    // One edge on TC, one on the cycle after: each window reports exactly one.
    wait_phase_a(99);
    if_a.sig_div = ~if_a.sig_div;
    tick();
    if_a.sig_div = ~if_a.sig_div;
    tick();
    chk("a_edge_on_tc_bcd", 32'(if_a.freq_bcd), 32'h001);
    wait_valid_a(150);
    chk("a_edge_after_tc_bcd", 32'(if_a.freq_bcd), 32'h001);

    // Hold across one TC: display frozen, no pulse; release and it updates.
    if_a.hold = 1'b1;
    run_toggle_a(100, 4, nv);
    chk("a_hold_valid_count", 32'(nv), 32'd0);
    chk("a_hold_bcd", 32'(if_a.freq_bcd), 32'h001);
    if_a.hold = 1'b0;
    run_toggle_a(100, 4, nv);
    chk("a_unhold_valid_count", 32'(nv), 32'd1);
    chk("a_unhold_bcd", 32'(if_a.freq_bcd), 32'h025);

    // Mid-window reset with sig_div high: first post-reset cycle counts as an edge.
    run_toggle_a(50, 4, nv);
    if_a.sig_div = 1'b1;
    rst_n_a = 1'b0;
    tick();
    chk("a_midrst_bcd",   32'(if_a.freq_bcd), 32'h0);
    chk("a_midrst_valid", 32'(if_a.valid),    32'h0);
    chk("a_midrst_ovf",   32'(if_a.ovf),      32'h0);
    rst_n_a = 1'b1;
    cnt = 0;
    while (!if_a.valid && cnt < 300) begin
      if ((cnt % 4) == 3) if_a.sig_div = ~if_a.sig_div;
      tick();
      cnt++;
    end
    chk("a_first_valid_latency", 32'(cnt), 32'd100);
    chk("a_post_rst_bcd", 32'(if_a.freq_bcd), 32'h026);

    guard = 0;
    while (!b_done && guard < 2000) begin
      tick();
      guard++;
    end
    chk("b_done", 32'(b_done), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : stim_b
    if_b.sig_div = 1'b0;
    if_b.hold    = 1'b0;
    rst_n_b      = 1'b0;
    tick();
    tick();
    chk("b_rst_bcd", 32'(if_b.freq_bcd), 32'h0);
    chk("b_rst_ovf", 32'(if_b.ovf),      32'h0);
    rst_n_b = 1'b1;

    // 150 edges into a 2-digit counter: saturates at 99 with overflow.
    for (int i = 0; i < 150; i++) begin
      if_b.sig_div = ~if_b.sig_div;
      tick();
    end
    chk("b_sat_valid", 32'(if_b.valid),    32'd1);
    chk("b_sat_bcd",   32'(if_b.freq_bcd), 32'h99);
    chk("b_sat_ovf",   32'(if_b.ovf),      32'd1);

    // Input stopped: next window is empty and the overflow flag clears.
    for (int i = 0; i < 150; i++) tick();
    chk("b_idle_valid", 32'(if_b.valid),    32'd1);
    chk("b_idle_bcd",   32'(if_b.freq_bcd), 32'h00);
    chk("b_idle_ovf",   32'(if_b.ovf),      32'd0);
    b_done = 1'b1;
  end

endmodule
